// File: rtl/serial_mem_loader_if.sv
// serial_mem_loader_if
// Bundles the UART byte stream and the memory-controller request bus used by
// serial_mem_loader.
//   master : the loader side (drives serial_data_out/serial_out_en and the
//            memory request signals mem_w_en/mem_r_en/mem_addr/mem_data_in)
//   slave  : the UART + memory controller side (drives received bytes, error
//            pulses, transmitter ready, mem_rdy/mem_cplt/mem_data_out)
interface serial_mem_loader_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  // UART receive / transmit
  logic [7:0]            serial_data_in;
  logic                  serial_in_cplt;
  logic                  serial_in_error;
  logic                  serial_out_rdy;
  logic [7:0]            serial_data_out;
  logic                  serial_out_en;
  // Memory controller
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_w_en;
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;

  modport master (
    input  serial_data_in, serial_in_cplt, serial_in_error, serial_out_rdy,
    input  mem_rdy, mem_cplt, mem_data_out,
    output serial_data_out, serial_out_en,
    output mem_w_en, mem_r_en, mem_addr, mem_data_in
  );

  modport slave (
    output serial_data_in, serial_in_cplt, serial_in_error, serial_out_rdy,
    output mem_rdy, mem_cplt, mem_data_out,
    input  serial_data_out, serial_out_en,
    input  mem_w_en, mem_r_en, mem_addr, mem_data_in
  );
endinterface

// File: rtl/serial_mem_loader.sv
// serial_mem_loader
// Byte-serial boot loader / debug monitor. Decodes opcode-framed commands from
// the UART and turns them into burst writes or burst reads on the memory bus,
// and controls the CPU run enable.
//   Commands: 0x00 WRITE addr[ADDR_BYTES] count data[count*DATA_BYTES]
//             0x01 READ  addr[ADDR_BYTES] count
//             0x02 RUN, 0x03 HALT; anything else is answered with NAK 0x15.
//   Multi-byte fields are LSB first; count 0 means 256 words.
//   WRITE answers 0x45 then an 8-bit sum of every byte after the opcode.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : serial_mem_loader_if.master (UART bytes + memory requests)
//   led[3:0]    : [0] rx error, [1] bad opcode, [2] timeout (sticky), [3] cpu_enable
//   cpu_enable  : CPU run enable
module serial_mem_loader #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_mem_loader_if.master        bus,
  output logic [3:0]                 led,
  output logic                       cpu_enable
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int DATA_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int AB_W       = ADDR_BYTES * 8;
  localparam int DB_W       = DATA_BYTES * 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int TMR_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [7:0] OP_WRITE = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_HALT  = 8'h03;
  localparam logic [7:0] ACK      = 8'h45;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [3:0] {
    IDLE, RX_ADDR, RX_LEN, RX_DATA, MEM_WR, MEM_RD_REQ, MEM_RD_WAIT,
    TX_DATA, TX_ACK, TX_CSUM, TX_NAK
  } state_t;

  state_t                state;
  logic [AB_W-1:0]       addr_buf;     // address bytes shifted in from the top
  logic [DB_W-1:0]       data_buf;     // write word being assembled / read word being sent
  logic [ADDR_WIDTH-1:0] addr;         // current word address of the burst
  logic [CNT_W-1:0]      byte_cnt;     // position inside the addr/data field
  logic [8:0]            word_cnt;     // words left in the burst (1..256)
  logic [7:0]            csum;
  logic                  is_read;
  logic                  send_csum;    // ACK is followed by the checksum (WRITE only)
  logic [TMR_W-1:0]      timer;
  logic [2:0]            led_sticky;
  logic                  cpu_en;
  logic [7:0]            tx_data;
  logic                  tx_en;
  logic                  w_en;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic rx_state;
  logic tx_ok;
  logic timeout_hit;

  assign rx_state    = (state == RX_ADDR) || (state == RX_LEN) || (state == RX_DATA);
  // A byte may only go out if the previous cycle did not already strobe.
  assign tx_ok       = bus.serial_out_rdy && !tx_en;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && rx_state && !bus.serial_in_cplt &&
                       (timer == TMR_LAST);

  // NOTE: all state here is written with non-blocking assignments so every
  // branch sees the values from the start of the cycle, matching the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_buf    <= '0;
      data_buf    <= '0;
      addr        <= '0;
      byte_cnt    <= '0;
      word_cnt    <= '0;
      csum        <= '0;
      is_read     <= 1'b0;
      send_csum   <= 1'b0;
      timer       <= '0;
      led_sticky  <= '0;
      cpu_en      <= 1'b0;
      tx_data     <= '0;
      tx_en       <= 1'b0;
      w_en        <= 1'b0;
      r_en        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Strobes are pulses: low unless a branch below raises them this cycle.
      tx_en <= 1'b0;
      w_en  <= 1'b0;
      r_en  <= 1'b0;

      // Inter-byte timer: cleared by every received byte and outside RX states.
      if (bus.serial_in_cplt || !rx_state) begin
        timer <= '0;
      end else if (!timeout_hit) begin
        timer <= timer + TMR_W'(1);
      end

      if (bus.serial_in_error) begin
        // Error beats any byte arriving in the same cycle; the command is dropped.
        led_sticky[0] <= 1'b1;
        state         <= TX_NAK;
      end else if (timeout_hit) begin
        // Words already written stay written; nothing is transmitted.
        led_sticky[2] <= 1'b1;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.serial_in_cplt) begin
              byte_cnt <= '0;
              csum     <= '0;
              case (bus.serial_data_in)
                OP_WRITE: begin is_read <= 1'b0; state <= RX_ADDR; end
                OP_READ:  begin is_read <= 1'b1; state <= RX_ADDR; end
                OP_RUN:   begin cpu_en <= 1'b1; send_csum <= 1'b0; state <= TX_ACK; end
                OP_HALT:  begin cpu_en <= 1'b0; send_csum <= 1'b0; state <= TX_ACK; end
                default:  begin led_sticky[1] <= 1'b1; state <= TX_NAK; end
              endcase
            end
          end

          RX_ADDR: begin
            if (bus.serial_in_cplt) begin
              // LSB arrives first, so shifting in from the top leaves it at bit 0.
              addr_buf <= AB_W'({bus.serial_data_in, addr_buf} >> 8);
              csum     <= csum + bus.serial_data_in;
              if (byte_cnt == ADDR_LAST) begin
                byte_cnt <= '0;
                state    <= RX_LEN;
              end else begin
                byte_cnt <= byte_cnt + CNT_W'(1);
              end
            end
          end

          RX_LEN: begin
            if (bus.serial_in_cplt) begin
              addr     <= addr_buf[ADDR_WIDTH-1:0];
              word_cnt <= (bus.serial_data_in == 8'h00) ? 9'd256 : {1'b0, bus.serial_data_in};
              csum     <= csum + bus.serial_data_in;
              byte_cnt <= '0;
              state    <= is_read ? MEM_RD_REQ : RX_DATA;
            end
          end

          RX_DATA: begin
            if (bus.serial_in_cplt) begin
              data_buf <= DB_W'({bus.serial_data_in, data_buf} >> 8);
              csum     <= csum + bus.serial_data_in;
              if (byte_cnt == DATA_LAST) begin
                byte_cnt <= '0;
                state    <= MEM_WR;
              end else begin
                byte_cnt <= byte_cnt + CNT_W'(1);
              end
            end
          end

          MEM_WR: begin
            if (bus.mem_rdy) begin
              w_en        <= 1'b1;
              mem_addr_q  <= addr;
              mem_wdata_q <= data_buf[DATA_WIDTH-1:0];
              addr        <= addr + ADDR_WIDTH'(1);
              word_cnt    <= word_cnt - 9'd1;
              if (word_cnt == 9'd1) begin
                send_csum <= 1'b1;
                state     <= TX_ACK;
              end else begin
                state <= RX_DATA;
              end
            end
          end

          MEM_RD_REQ: begin
            if (bus.mem_rdy) begin
              r_en       <= 1'b1;
              mem_addr_q <= addr;
              state      <= MEM_RD_WAIT;
            end
          end

          MEM_RD_WAIT: begin
            if (bus.mem_cplt) begin
              data_buf <= DB_W'(bus.mem_data_out);
              byte_cnt <= '0;
              state    <= TX_DATA;
            end
          end

          TX_DATA: begin
            if (tx_ok) begin
              tx_en    <= 1'b1;
              tx_data  <= data_buf[7:0];
              data_buf <= data_buf >> 8;
              if (byte_cnt == DATA_LAST) begin
                byte_cnt <= '0;
                addr     <= addr + ADDR_WIDTH'(1);
                word_cnt <= word_cnt - 9'd1;
                state    <= (word_cnt == 9'd1) ? IDLE : MEM_RD_REQ;
              end else begin
                byte_cnt <= byte_cnt + CNT_W'(1);
              end
            end
          end

          TX_ACK: begin
            if (tx_ok) begin
              tx_en   <= 1'b1;
              tx_data <= ACK;
              state   <= send_csum ? TX_CSUM : IDLE;
            end
          end

          TX_CSUM: begin
            if (tx_ok) begin
              tx_en   <= 1'b1;
              tx_data <= csum;
              state   <= IDLE;
            end
          end

          TX_NAK: begin
            if (tx_ok) begin
              tx_en   <= 1'b1;
              tx_data <= NAK;
              state   <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.serial_data_out = tx_data;
  assign bus.serial_out_en   = tx_en;
  assign bus.mem_w_en        = w_en;
  assign bus.mem_r_en        = r_en;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_data_in     = mem_wdata_q;
  assign led                 = {cpu_en, led_sticky};
  assign cpu_enable          = cpu_en;

endmodule

// File: tb/tb_serial_mem_loader.sv
// tb_serial_mem_loader
// Directed bench for serial_mem_loader. A small behavioural model (queues of
// expected transmit bytes, expected writes and expected read addresses, plus a
// word-addressed memory) is filled by the command tasks; one compare process
// checks every strobe against it. Literal byte sequences pin the model.
module tb_serial_mem_loader;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] led;
  logic cpu_enable;

  always #5 clk = ~clk;

  serial_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  serial_mem_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .led        (led),
    .cpu_enable (cpu_enable)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [7:0]    exp_tx [$];
  wr_t           exp_wr [$];
  logic [AW-1:0] exp_rd [$];
  logic [7:0]    tx_log [$];

  int n_checks = 0;
  int n_fail   = 0;
  int w_count  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory controller responder ----------------
  logic          rdy_s   = 1'b0;
  logic          rd_pend = 1'b0;
  int            rd_wait = 0;
  logic [AW-1:0] rd_addr = '0;

  always @(posedge clk) begin
    rdy_s = bus.mem_rdy;
    #1;
    bus.mem_cplt = 1'b0;
    if (rd_pend) begin
      if (rd_wait == 0) begin
        bus.mem_cplt     = 1'b1;
        bus.mem_data_out = mem_model.exists(rd_addr) ? mem_model[rd_addr] : '0;
        rd_pend          = 1'b0;
      end else begin
        rd_wait--;
      end
    end
    if (bus.mem_r_en && rst_n) begin
      rd_pend = 1'b1;
      rd_wait = 2;
      rd_addr = bus.mem_addr;
    end
  end

  // ---------------- compare process ----------------
  logic prev_en = 1'b0;
  wr_t  e_wr;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.serial_out_en) begin
        check("tx_spacing", 32'(prev_en), 32'd0);
        tx_log.push_back(bus.serial_data_out);
        if (exp_tx.size() == 0) check("tx_unexpected", 32'(exp_tx.size()), 32'd1);
        else check("tx_byte", 32'(bus.serial_data_out), 32'(exp_tx.pop_front()));
      end
      prev_en = bus.serial_out_en;
      if (bus.mem_w_en || bus.mem_r_en) begin
        check("strobe_exclusive", 32'(bus.mem_w_en & bus.mem_r_en), 32'd0);
        check("strobe_rdy", 32'(rdy_s), 32'd1);
      end
      if (bus.mem_w_en) begin
        w_count++;
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
        else begin
          e_wr = exp_wr.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(e_wr.a));
          check("wr_data", 32'(bus.mem_data_in), 32'(e_wr.d));
        end
        mem_model[bus.mem_addr] = bus.mem_data_in;
      end
      if (bus.mem_r_en) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 32'(exp_rd.size()), 32'd1);
        else check("rd_addr", 32'(bus.mem_addr), 32'(exp_rd.pop_front()));
      end
    end else begin
      prev_en = 1'b0;
    end
  end

  // ---------------- host side ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.serial_data_in = b;
    bus.serial_in_cplt = 1'b1;
    @(posedge clk); #1;
    bus.serial_in_cplt = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_err_with_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.serial_data_in  = b;
    bus.serial_in_cplt  = 1'b1;
    bus.serial_in_error = 1'b1;
    @(posedge clk); #1;
    bus.serial_in_cplt  = 1'b0;
    bus.serial_in_error = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_header(input logic [7:0] op, input logic [AW-1:0] a, input int n);
    send_byte(op);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(a[23:16]);
    send_byte(n[7:0]);
  endtask

  // Model of a WRITE: consecutive wrapping addresses, ACK, then the 8-bit sum
  // of everything after the opcode.
  task automatic expect_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] w [4]);
    logic [7:0] s;
    s = a[7:0] + a[15:8] + a[23:16] + n[7:0];
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back('{a: a + AW'(i), d: w[i]});
      s = s + w[i][7:0] + w[i][15:8];
    end
    exp_tx.push_back(8'h45);
    exp_tx.push_back(s);
  endtask

  task automatic cmd_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] w [4]);
    expect_write(a, n, w);
    send_header(8'h00, a, n);
    for (int i = 0; i < n; i++) begin
      send_byte(w[i][7:0]);
      send_byte(w[i][15:8]);
    end
  endtask

  task automatic expect_read(input logic [AW-1:0] a, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(a + AW'(i));
      d = mem_model.exists(a + AW'(i)) ? mem_model[a + AW'(i)] : '0;
      exp_tx.push_back(d[7:0]);
      exp_tx.push_back(d[15:8]);
    end
  endtask

  task automatic cmd_read(input logic [AW-1:0] a, input int n);
    expect_read(a, n);
    send_header(8'h01, a, n);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_tx.size() + exp_wr.size() + exp_rd.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", 32'(exp_tx.size() + exp_wr.size() + exp_rd.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_log(input string name, input int n, input logic [7:0] b [4]);
    check({name, "_len"}, 32'(tx_log.size()), 32'(n));
    for (int i = 0; i < n && i < tx_log.size(); i++)
      check({name, "_byte"}, 32'(tx_log[i]), 32'(b[i]));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_en"}, 32'(bus.serial_out_en), 32'd0);
    check({name, "_tx_data"}, 32'(bus.serial_data_out), 32'd0);
    check({name, "_w_en"}, 32'(bus.mem_w_en), 32'd0);
    check({name, "_r_en"}, 32'(bus.mem_r_en), 32'd0);
    check({name, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({name, "_wdata"}, 32'(bus.mem_data_in), 32'd0);
    check({name, "_led"}, 32'(led), 32'd0);
    check({name, "_cpu"}, 32'(cpu_enable), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int w0;

  initial begin
    bus.serial_data_in  = '0;
    bus.serial_in_cplt  = 1'b0;
    bus.serial_in_error = 1'b0;
    bus.serial_out_rdy  = 1'b1;
    bus.mem_rdy         = 1'b1;
    mem_model[24'hFFFFFF] = 16'hBEEF;
    mem_model[24'h000000] = 16'hCAFE;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // WRITE 0x000010, two words. Sum 10+00+00+02+34+12+78+56 = 0x126 -> 0x26.
    tx_log.delete();
    cmd_write(24'h000010, 2, '{16'h1234, 16'h5678, 16'h0000, 16'h0000});
    wait_drain(200);
    expect_log("write_ack", 2, '{8'h45, 8'h26, 8'h00, 8'h00});
    check("write_led", 32'(led), 32'h0);

    // READ across the top of the address space
    tx_log.delete();
    cmd_read(24'hFFFFFF, 2);
    wait_drain(200);
    expect_log("read_wrap", 4, '{8'hEF, 8'hBE, 8'hFE, 8'hCA});

    // Bad opcode, then a READ of a word written earlier
    tx_log.delete();
    exp_tx.push_back(8'h15);
    send_byte(8'h07);
    wait_drain(100);
    expect_log("bad_op_nak", 1, '{8'h15, 8'h00, 8'h00, 8'h00});
    check("bad_op_led", 32'(led), 32'b0010);
    tx_log.delete();
    cmd_read(24'h000010, 1);
    wait_drain(200);
    expect_log("read_after_nak", 2, '{8'h34, 8'h12, 8'h00, 8'h00});

    // WRITE while memory is not ready
    tx_log.delete();
    bus.mem_rdy = 1'b0;
    expect_write(24'h000040, 2, '{16'h2211, 16'h4433, 16'h0000, 16'h0000});
    send_header(8'h00, 24'h000040, 2);
    w0 = w_count;
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (50) @(negedge clk);
    check("stall_no_write", 32'(w_count - w0), 32'd0);
    bus.mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_one_write", 32'(w_count - w0), 32'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_drain(200);
    check("stall_two_writes", 32'(w_count - w0), 32'd2);
    expect_log("stall_ack", 2, '{8'h45, 8'hEC, 8'h00, 8'h00});

    // Inter-byte timeout (100 cycles), then RUN
    tx_log.delete();
    send_byte(8'h00);
    send_byte(8'h10);
    repeat (90) @(negedge clk);
    check("timeout_not_yet", 32'(led[2]), 32'd0);
    repeat (10) @(negedge clk);
    check("timeout_led", 32'(led), 32'b0110);
    check("timeout_silent", 32'(tx_log.size()), 32'd0);
    exp_tx.push_back(8'h45);
    send_byte(8'h02);
    wait_drain(100);
    check("run_cpu", 32'(cpu_enable), 32'd1);
    check("run_led", 32'(led), 32'b1110);
    expect_log("run_ack", 1, '{8'h45, 8'h00, 8'h00, 8'h00});

    // Receive error coinciding with the byte that would complete a word
    tx_log.delete();
    w0 = w_count;
    exp_tx.push_back(8'h15);
    send_header(8'h00, 24'h000020, 1);
    send_byte(8'h34);
    send_err_with_byte(8'h12);
    wait_drain(100);
    repeat (10) @(negedge clk);
    check("err_no_write", 32'(w_count - w0), 32'd0);
    check("err_led", 32'(led), 32'b1111);
    expect_log("err_nak", 1, '{8'h15, 8'h00, 8'h00, 8'h00});

    // Reset in the middle of a READ (transmitter held busy)
    tx_log.delete();
    bus.serial_out_rdy = 1'b0;
    expect_read(24'h000010, 1);
    send_header(8'h01, 24'h000010, 1);
    repeat (12) @(negedge clk);
    check("midread_held", 32'(tx_log.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_tx.delete();
    exp_rd.delete();
    @(negedge clk);
    check_all_zero("midread_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.serial_out_rdy = 1'b1;
    repeat (20) @(negedge clk);
    check("midread_silent", 32'(tx_log.size()), 32'd0);

    // RUN then HALT
    exp_tx.push_back(8'h45);
    send_byte(8'h02);
    wait_drain(100);
    check("run2_cpu", 32'(cpu_enable), 32'd1);
    check("run2_led", 32'(led), 32'b1000);
    exp_tx.push_back(8'h45);
    send_byte(8'h03);
    wait_drain(100);
    check("halt_cpu", 32'(cpu_enable), 32'd0);
    check("halt_led", 32'(led), 32'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
